// File: rtl/usb_rx_pkg.sv
// Shared types for the low-speed USB receive path.
// Line-state encodings and the receiver state enum.
package usb_rx_pkg;

   typedef logic [1:0] d_port_t;

   // Low-speed polarity: idle J is D- high.
   localparam d_port_t J   = 2'b01;
   localparam d_port_t K   = 2'b10;
   localparam d_port_t SE0 = 2'b00;
   localparam d_port_t SE1 = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP,
      ERROR
   } rx_state_t;

endpackage

// File: rtl/usb_rx_if.sv
// Line input and byte-stream outputs of the USB receiver.
// master = receiver side, slave = line driver / byte consumer.
interface usb_rx_if;
   import usb_rx_pkg::*;

   d_port_t    line_state;
   logic [7:0] rx_data;
   logic       rx_active;
   logic       rx_valid;
   logic       rx_error;

   modport master (
      input  line_state,
      output rx_data,
      output rx_active,
      output rx_valid,
      output rx_error
   );

   modport slave (
      output line_state,
      input  rx_data,
      input  rx_active,
      input  rx_valid,
      input  rx_error
   );

endinterface

// File: rtl/usb_rx_dpll.sv
// Bit-clock recovery and NRZI decode for the USB receiver.
// Phase restarts on every line edge; strobe lands mid-bit.
module usb_rx_dpll
   import usb_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic    clk,
   input  logic    reset,
   input  d_port_t line_state,
   output logic    strobe,
   output logic    dbit,
   output logic    k,
   output logic    se0,
   output logic    se1
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   logic [CW-1:0] cnt;
   d_port_t       line_q;
   d_port_t       prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         line_q <= J;
         prev   <= J;
      end else begin
         line_q <= line_state;
         if (line_state != line_q)
            cnt <= '0;
         else if (cnt == CW'(CLKS_PER_BIT - 1))
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         // Only J/K samples advance the NRZI reference.
         if (strobe && (line_q == J || line_q == K))
            prev <= line_q;
      end
   end

   assign strobe = (cnt == CW'(CLKS_PER_BIT / 2));
   assign dbit   = (line_q == prev);
   assign k      = (line_q == K);
   assign se0    = (line_q == SE0);
   assign se1    = (line_q == SE1);

endmodule

// File: rtl/usb_rx.sv
// Low-speed USB receive SIE: SYNC hunt, bit unstuffing,
// LSB-first byte assembly, EOP and error handling.
module usb_rx
   import usb_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT   = 16,
   parameter int MIN_SYNC_ZEROS = 5
) (
   input  logic     clk,
   input  logic     reset,
   usb_rx_if.master bus
);

   logic stb, dbit, k, se0, se1, jsmp;

   usb_rx_dpll #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_dpll (
      .clk       (clk),
      .reset     (reset),
      .line_state(bus.line_state),
      .strobe    (stb),
      .dbit      (dbit),
      .k         (k),
      .se0       (se0),
      .se1       (se1)
   );

   assign jsmp = !k && !se0 && !se1;

   rx_state_t  state, state_n;
   logic [3:0] zcnt;
   logic [2:0] ones;
   logic [2:0] bcnt;
   logic [6:0] sh;
   logic [1:0] se0cnt;
   logic [2:0] jcnt;
   logic       seen_se0;
   logic [7:0] rx_data;
   logic       rx_active, rx_valid, rx_error;

   logic err_enter, pkt_end, start;
   logic data_bit, stuff_bit, eop_enter;

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (stb && k) state_n = SYNC;
         SYNC: if (stb) begin
            if (se0 || se1)
               state_n = IDLE;
            else if (dbit)
               state_n = (zcnt >= 4'(MIN_SYNC_ZEROS)) ? DATA : IDLE;
         end
         DATA: if (stb) begin
            if (se1)
               state_n = ERROR;
            else if (se0)
               state_n = (bcnt != 3'd0) ? ERROR : EOP;
            else if (ones == 3'd6 && dbit)
               state_n = ERROR;
         end
         EOP: if (stb) begin
            if (jsmp)
               state_n = IDLE;
            else if (k || se1 || se0cnt == 2'd3)
               state_n = ERROR;
         end
         ERROR: if (stb && jsmp && (seen_se0 || jcnt == 3'd7))
            state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      err_enter = stb && state != ERROR && state_n == ERROR;
      pkt_end   = stb && state_n == IDLE &&
                  (state == EOP || state == ERROR);
      start     = state == SYNC && state_n == DATA;
      data_bit  = stb && state == DATA && state_n == DATA &&
                  ones != 3'd6;
      stuff_bit = stb && state == DATA && state_n == DATA &&
                  ones == 3'd6;
      eop_enter = state == DATA && state_n == EOP;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         zcnt      <= '0;
         ones      <= '0;
         bcnt      <= '0;
         sh        <= '0;
         se0cnt    <= '0;
         jcnt      <= '0;
         seen_se0  <= 1'b0;
         rx_data   <= '0;
         rx_active <= 1'b0;
         rx_valid  <= 1'b0;
         rx_error  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (state == IDLE)
            zcnt <= 4'd1;
         else if (state == SYNC && stb && jsmp | k && !dbit &&
                  zcnt != 4'hf)
            zcnt <= zcnt + 1'b1;
         if (start) begin
            rx_active <= 1'b1;
            ones      <= '0;
            bcnt      <= '0;
         end
         if (data_bit) begin
            sh   <= {dbit, sh[6:1]};
            ones <= dbit ? ones + 1'b1 : 3'd0;
            bcnt <= bcnt + 1'b1;
            if (bcnt == 3'd7) begin
               rx_data  <= {dbit, sh};
               rx_valid <= 1'b1;
            end
         end
         if (stuff_bit)
            ones <= '0;
         if (eop_enter)
            se0cnt <= 2'd1;
         else if (state == EOP && stb && se0)
            se0cnt <= se0cnt + 1'b1;
         if (err_enter) begin
            rx_valid <= 1'b1;
            rx_error <= 1'b1;
            seen_se0 <= se0;
            jcnt     <= '0;
         end else if (state == ERROR && stb) begin
            unique case (1'b1)
               se0: begin
                  seen_se0 <= 1'b1;
                  jcnt     <= '0;
               end
               jsmp: jcnt <= jcnt + 1'b1;
               default: begin
                  seen_se0 <= 1'b0;
                  jcnt     <= '0;
               end
            endcase
         end
         if (pkt_end) begin
            rx_active <= 1'b0;
            rx_error  <= 1'b0;
         end
      end
   end

   assign bus.rx_data   = rx_data;
   assign bus.rx_active = rx_active;
   assign bus.rx_valid  = rx_valid;
   assign bus.rx_error  = rx_error;

endmodule

// File: tb/tb_usb_rx.sv
// Bench for usb_rx: builds NRZI/stuffed line streams from bytes,
// drives them with edge jitter and checks every byte pulse.
module tb_usb_rx;
   import usb_rx_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   usb_rx_if bus();

   usb_rx #(
      .CLKS_PER_BIT  (16),
      .MIN_SYNC_ZEROS(5)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic [7:0] d;
      logic       e;
   } exp_t;

   exp_t    expq[$];
   d_port_t sym[$];
   d_port_t lvl;
   int      run;
   int      cur_j;
   int      checks = 0;
   int      errors = 0;
   int      rises  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One bit onto the wire: NRZI (0 toggles), optional stuffing.
   task automatic nb(input logic b, input bit stf);
      if (!b) lvl = (lvl == J) ? K : J;
      sym.push_back(lvl);
      if (stf) begin
         run = b ? run + 1 : 0;
         if (run == 6) begin
            lvl = (lvl == J) ? K : J;
            sym.push_back(lvl);
            run = 0;
         end
      end
   endtask

   task automatic add_sync(input int nz);
      lvl = J;
      for (int i = 0; i < nz; i++) nb(1'b0, 1'b0);
      nb(1'b1, 1'b0);
      run = 0;
   endtask

   task automatic add_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) nb(v[i], 1'b1);
      expq.push_back('{v, 1'b0});
   endtask

   task automatic add_err();
      expq.push_back('{8'h00, 1'b1});
   endtask

   task automatic add_eop();
      sym.push_back(SE0);
      sym.push_back(SE0);
      sym.push_back(J);
      lvl = J;
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) sym.push_back(J);
      lvl = J;
   endtask

   // Each edge lands at its nominal bit boundary +/-3 clk.
   task automatic play();
      d_port_t s;
      int      nj;
      while (sym.size() > 0) begin
         s  = sym.pop_front();
         nj = int'($urandom_range(6)) - 3;
         bus.line_state = s;
         repeat (16 + nj - cur_j) @(negedge clk);
         cur_j = nj;
      end
   endtask

   task automatic end_pkt(input string name, input int exp_rises);
      repeat (24) @(negedge clk);
      chk({name, "_pending"}, expq.size(), 0);
      chk({name, "_active"}, bus.rx_active, 1'b0);
      chk({name, "_error"}, bus.rx_error, 1'b0);
      chk({name, "_rises"}, rises, exp_rises);
      rises = 0;
      expq.delete();
   endtask

   task automatic send_a5(input string name);
      add_sync(7);
      add_byte(8'hA5);
      add_eop();
      add_idle(12);
      play();
      end_pkt(name, 1);
   endtask

   initial begin
      logic pa;
      logic eh;
      exp_t e;
      pa = 1'b0;
      eh = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pa = 1'b0;
            eh = 1'b0;
         end else begin
            if (bus.rx_valid) begin
               if (expq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL pulse_unexpected: got data=%h err=%b, none expected",
                           bus.rx_data, bus.rx_error);
               end else begin
                  e = expq.pop_front();
                  chk("pulse_err", bus.rx_error, e.e);
                  if (!e.e) chk("pulse_data", bus.rx_data, e.d);
               end
               chk("valid_in_pkt", bus.rx_active, 1'b1);
               if (bus.rx_error) eh = 1'b1;
            end
            if (eh && bus.rx_active) chk("err_hold", bus.rx_error, 1'b1);
            if (!bus.rx_active) begin
               chk("err_outside", bus.rx_error, 1'b0);
               eh = 1'b0;
            end
            if (bus.rx_active && !pa) rises++;
            pa = bus.rx_active;
         end
      end
   end

   initial begin
      logic [31:0] pin;
      reset = 1'b1;
      bus.line_state = J;
      cur_j = 0;
      lvl = J;
      run = 0;
      repeat (5) @(negedge clk);
      chk("rst_active", bus.rx_active, 1'b0);
      chk("rst_valid", bus.rx_valid, 1'b0);
      chk("rst_error", bus.rx_error, 1'b0);
      chk("rst_data", bus.rx_data, 8'h00);
      reset = 1'b0;
      add_idle(4);
      play();

      // Encoder pin: KJKJKJKK then A5 -> KJJKJJKK
      add_sync(7);
      add_byte(8'hA5);
      pin = '0;
      for (int i = 0; i < 16; i++) pin = {pin[29:0], sym[i]};
      chk("encode_a5", pin, 32'h999A965A);
      add_eop();
      add_idle(12);
      play();
      end_pkt("a5", 1);

      add_sync(7);
      add_byte(8'hFF);
      add_byte(8'hFF);
      add_eop();
      chk("ffff_len", sym.size(), 29);
      add_idle(12);
      play();
      end_pkt("ffff", 1);

      add_sync(7);
      repeat (7) sym.push_back(lvl);
      add_err();
      add_idle(12);
      play();
      end_pkt("stuff_err", 1);

      add_sync(3);
      add_eop();
      add_idle(12);
      play();
      end_pkt("short_sync", 0);

      add_sync(7);
      add_byte(8'($urandom));
      for (int i = 0; i < 4; i++) nb(1'($urandom), 1'b1);
      add_err();
      add_eop();
      add_idle(12);
      play();
      end_pkt("bits12", 1);

      add_sync(6);
      add_byte(8'($urandom));
      sym.push_back(SE1);
      add_err();
      add_eop();
      add_idle(12);
      play();
      end_pkt("se1", 1);

      add_sync(5);
      add_byte(8'($urandom));
      repeat (5) sym.push_back(SE0);
      add_err();
      add_idle(12);
      play();
      end_pkt("long_se0", 1);

      for (int p = 0; p < 30; p++) begin
         add_sync(int'($urandom_range(7, 5)));
         for (int b = 0; b < int'($urandom_range(4, 1)); b++)
            add_byte(8'($urandom));
         add_eop();
         add_idle(12);
         play();
         end_pkt("random", 1);
      end

      add_sync(7);
      add_byte(8'($urandom));
      for (int i = 0; i < 4; i++) nb(1'($urandom), 1'b1);
      play();
      repeat (4) @(negedge clk);
      bus.line_state = J;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_rst_active", bus.rx_active, 1'b0);
      chk("mid_rst_valid", bus.rx_valid, 1'b0);
      chk("mid_rst_error", bus.rx_error, 1'b0);
      chk("mid_rst_data", bus.rx_data, 8'h00);
      chk("mid_rst_pending", expq.size(), 0);
      reset = 1'b0;
      rises = 0;
      cur_j = 0;
      add_idle(4);
      play();
      send_a5("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
